// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : Iterative RV32M multiply/divide execute unit. One operation in
//             flight, valid/ready handshake on issue and writeback sides.
//             Multiply is radix-2 shift-add, divide is radix-2 restoring; both
//             work on absolute values and fix up signs in a final cycle.
//  Ports    : clk, rst_n (async, active-low)
//             in_valid/in_ready, op (funct3), rs1_data, rs2_data, rd_in
//             flush (synchronous abort)
//             out_valid/out_ready, result, rd_out, busy
//  Options  : MULDIV_FAST_MUL_EN - when defined, ops 0-3 use a single-cycle
//             combinational multiplier and complete on the accept edge.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [2:0]      op_q;
  logic [2*XLEN-1:0] acc;     // mul: {partial sum, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0] b_q;
  logic [CW-1:0]   cnt;
  logic            neg_lo;    // negate product / quotient
  logic            neg_hi;    // negate remainder (sign of dividend)

  // ---------------- accept-time decode ----------------
  logic            accept;
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;
  logic            fast_hit;
  logic [XLEN-1:0] fast_res;
  logic            done_now;
  logic [XLEN-1:0] done_res;

  assign accept   = (state == IDLE) && in_valid && !flush;
  // MUL (op 0) low half is sign-agnostic, so it is treated as unsigned.
  assign a_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
  assign b_signed = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
  assign a_neg    = a_signed && rs1_data[XLEN-1];
  assign b_neg    = b_signed && rs2_data[XLEN-1];
  assign a_abs    = a_neg ? -rs1_data : rs1_data;
  assign b_abs    = b_neg ? -rs2_data : rs2_data;

  assign div_zero = op[2] && (rs2_data == '0);
  assign div_ovf  = ((op == 3'd4) || (op == 3'd6)) &&
                    (rs1_data == MIN_NEG) && (rs2_data == '1);
  assign special  = div_zero || div_ovf;
  // op[1] distinguishes REM/REMU from DIV/DIVU within the divide group.
  assign special_res = div_zero ? (op[1] ? rs1_data : '1)
                                : (op[1] ? '0 : MIN_NEG);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN+1:0] fa, fb, fprod;
  assign fa       = {{(XLEN+2){a_signed && rs1_data[XLEN-1]}}, rs1_data};
  assign fb       = {{(XLEN+2){b_signed && rs2_data[XLEN-1]}}, rs2_data};
  assign fprod    = fa * fb;
  assign fast_hit = !op[2];
  assign fast_res = (op == 3'd0) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
`else
  assign fast_hit = 1'b0;
  assign fast_res = '0;
`endif

  assign done_now = special || fast_hit;
  assign done_res = special ? special_res : fast_res;

  // ---------------- iteration step ----------------
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_sh;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] acc_step;

  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} +
                    (acc[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
  assign div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_diff = {1'b0, div_sh} - {2'b00, b_q};

  always_comb begin
    acc_step = acc;
    if (!op_q[2]) begin
      acc_step = {mul_sum, acc[XLEN-1:1]};
    end else if (!div_diff[XLEN+1]) begin
      // Shifted remainder >= divisor: keep the difference, quotient bit 1.
      acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      acc_step = {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end
  end

  // ---------------- sign fix-up ----------------
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  assign prod_fix = neg_lo ? -acc : acc;
  assign quo_fix  = neg_lo ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem_fix  = neg_hi ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = '0;
    case (op_q)
      3'd0:          fix_res = prod_fix[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:          fix_res = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:    fix_res = quo_fix;
      default:       fix_res = rem_fix;
    endcase
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (in_valid) state_nxt = done_now ? DONE : CALC;
        CALC: if (cnt == CW'(XLEN-1)) state_nxt = FIX;
        FIX:  state_nxt = DONE;
        DONE: if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      acc    <= '0;
      b_q    <= '0;
      cnt    <= '0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      result <= '0;
      rd_out <= '0;
    end else if (accept) begin
      op_q   <= op;
      acc    <= {{XLEN{1'b0}}, a_abs};
      b_q    <= b_abs;
      cnt    <= '0;
      neg_lo <= a_neg ^ b_neg;
      neg_hi <= a_neg;
      rd_out <= rd_in;
      if (done_now) result <= done_res;
    end else if (state == CALC) begin
      acc <= acc_step;
      cnt <= cnt + CW'(1);
    end else if (state == FIX) begin
      result <= fix_res;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_unit
//  Purpose  : Directed, table-driven bench for muldiv_unit plus hand-written
//             sequences for DONE back-pressure, flush and mid-op reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [2:0]  op;
  logic [31:0] rs1_data, rs2_data, result;
  logic [4:0]  rd_in, rd_out;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .rd_in     (rd_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .rd_out    (rd_out),
    .busy      (busy)
  );

`ifdef MULDIV_FAST_MUL_EN
  localparam int ML = 1;
`else
  localparam int ML = 34;
`endif
  localparam int DL = 34;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 20;
  vec_t vt[NV];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    op = o; rs1_data = a; rs2_data = b; rd_in = rd; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Returns edges from (and including) the accept edge until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int lat;
    check({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    issue(v.op, v.a, v.b, v.rd);
    wait_valid(lat);
    check({name, "_latency"}, lat, v.lat);
    check({name, "_result"}, result, v.exp);
    check({name, "_rd_out"}, {27'd0, rd_out}, {27'd0, v.rd});
    consume();
    check({name, "_idle_after"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    logic [31:0] held;
    vt[0]  = '{3'd0, 32'h00000007, 32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, ML};
    vt[1]  = '{3'd1, 32'h80000000, 32'hFFFFFFFF, 5'd1,  32'h00000000, ML};
    vt[2]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 5'd2,  32'h80000000, ML};
    vt[3]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 5'd3,  32'h7FFFFFFF, ML};
    vt[4]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFE, ML};
    vt[5]  = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'h00000001, ML};
    vt[6]  = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 5'd7,  32'hFFFFFFFD, DL};
    vt[7]  = '{3'd6, 32'hFFFFFFF9, 32'h00000002, 5'd8,  32'hFFFFFFFF, DL};
    vt[8]  = '{3'd5, 32'hFFFFFFF9, 32'h00000002, 5'd9,  32'h7FFFFFFC, DL};
    vt[9]  = '{3'd7, 32'hFFFFFFF9, 32'h00000002, 5'd10, 32'h00000001, DL};
    vt[10] = '{3'd4, 32'h00000005, 32'h00000000, 5'd11, 32'hFFFFFFFF, 1};
    vt[11] = '{3'd6, 32'h00000005, 32'h00000000, 5'd12, 32'h00000005, 1};
    vt[12] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 1};
    vt[13] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h00000000, 1};
    vt[14] = '{3'd5, 32'h00000005, 32'h00000000, 5'd15, 32'hFFFFFFFF, 1};
    vt[15] = '{3'd7, 32'h00000005, 32'h00000000, 5'd16, 32'h00000005, 1};
    vt[16] = '{3'd5, 32'd100,      32'd7,        5'd0,  32'd14,       DL};
    vt[17] = '{3'd7, 32'd100,      32'd7,        5'd31, 32'd2,        DL};
    vt[18] = '{3'd4, 32'd7,        32'hFFFFFFFE, 5'd17, 32'hFFFFFFFD, DL};
    vt[19] = '{3'd6, 32'd7,        32'hFFFFFFFE, 5'd18, 32'h00000001, DL};

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    op = '0; rs1_data = '0; rs2_data = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready",  {31'd0, in_ready},  32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_busy",      {31'd0, busy},      32'd0);
    check("reset_result",    result,             32'd0);
    check("reset_rd_out",    {27'd0, rd_out},    32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Back-pressure: DONE must hold while out_ready stays low.
    issue(3'd0, 32'h00000007, 32'hFFFFFFFD, 5'd5);
    wait_valid(lat);
    check("hold_latency", lat, ML);
    held = result;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_in_ready",  {31'd0, in_ready},  32'd0);
      check("hold_result",    result,             32'hFFFFFFEB);
    end
    consume();
    check("release_in_ready",  {31'd0, in_ready},  32'd1);
    check("release_out_valid", {31'd0, out_valid}, 32'd0);

    // Flush at CALC cycle 10.
    issue(3'd5, 32'd100, 32'd7, 5'd3);
    repeat (9) @(posedge clk);
    #1;
    check("pre_flush_busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready",  {31'd0, in_ready},  32'd1);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_busy",      {31'd0, busy},      32'd0);
    run_vec('{3'd5, 32'd100, 32'd7, 5'd20, 32'd14, DL}, "post_flush");

    // Flush in IDLE with a request pending: nothing accepted.
    op = 3'd5; rs1_data = 32'd100; rs2_data = 32'd7; rd_in = 5'd1;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("idle_flush_in_ready", {31'd0, in_ready}, 32'd1);
    check("idle_flush_busy",     {31'd0, busy},     32'd0);

    // Asynchronous reset in the middle of CALC.
    issue(3'd4, 32'hFFFFFFF9, 32'd2, 5'd9);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready",  {31'd0, in_ready},  32'd1);
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_busy",      {31'd0, busy},      32'd0);
    check("arst_result",    result,             32'd0);
    check("arst_rd_out",    {27'd0, rd_out},    32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec('{3'd5, 32'd100, 32'd7, 5'd21, 32'd14, DL}, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
